// File: rtl/xy_scan_out.sv
// rtl/xy_scan_out.sv - round-robin XY point scanner driving 8-bit X/Y/Z DAC outputs with dwell timing
// Define XY_SCAN_BLANK_EN to add large-jump detection and the blanked SETTLE state.
module xy_scan_out #(
  parameter int DWELL_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int JUMP_THRESH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] src0_x,
  input  logic [7:0] src0_y,
  input  logic       src0_valid,
  output logic       src0_ready,
  input  logic [7:0] src1_x,
  input  logic [7:0] src1_y,
  input  logic       src1_valid,
  output logic       src1_ready,
  input  logic [7:0] src2_x,
  input  logic [7:0] src2_y,
  input  logic       src2_valid,
  output logic       src2_ready,
  output logic [7:0] dac_x,
  output logic [7:0] dac_y,
  output logic       dac_z,
  output logic       frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

`ifdef XY_SCAN_BLANK_EN
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [8:0]    THRESH      = 9'(JUMP_THRESH);
  typedef enum logic [1:0] {ARB, SETTLE, DWELL} state_t;
`else
  typedef enum logic {ARB, DWELL} state_t;
`endif

  state_t        state, state_d;
  logic [1:0]    ptr, ptr_d, ptr_inc;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    x_d, y_d;
  logic          wrap;
  logic          sel_valid;
  logic [7:0]    sel_x, sel_y;
  logic          jump;

  always_comb begin
    sel_valid = 1'b0;
    sel_x     = src0_x;
    sel_y     = src0_y;
    case (ptr)
      2'd0: begin sel_valid = src0_valid; sel_x = src0_x; sel_y = src0_y; end
      2'd1: begin sel_valid = src1_valid; sel_x = src1_x; sel_y = src1_y; end
      2'd2: begin sel_valid = src2_valid; sel_x = src2_x; sel_y = src2_y; end
      default: sel_valid = 1'b0;
    endcase
  end

  assign ptr_inc = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;

`ifdef XY_SCAN_BLANK_EN
  // Distance is measured against the point currently on the DAC, before it is replaced.
  logic [8:0] diff_x, diff_y, dist_x, dist_y;
  assign diff_x = {1'b0, sel_x} - {1'b0, dac_x};
  assign diff_y = {1'b0, sel_y} - {1'b0, dac_y};
  assign dist_x = diff_x[8] ? (9'd0 - diff_x) : diff_x;
  assign dist_y = diff_y[8] ? (9'd0 - diff_y) : diff_y;
  assign jump   = (dist_x > THRESH) || (dist_y > THRESH);
`else
  assign jump = 1'b0;
`endif

  // Readiness is gated by rst_n so a held valid is never acknowledged during reset.
  assign src0_ready = rst_n & (state == ARB) & (ptr == 2'd0) & src0_valid;
  assign src1_ready = rst_n & (state == ARB) & (ptr == 2'd1) & src1_valid;
  assign src2_ready = rst_n & (state == ARB) & (ptr == 2'd2) & src2_valid;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    x_d     = dac_x;
    y_d     = dac_y;
    wrap    = 1'b0;
    case (state)
      ARB: begin
        if (sel_valid) begin
          x_d   = sel_x;
          y_d   = sel_y;
          cnt_d = '0;
`ifdef XY_SCAN_BLANK_EN
          state_d = jump ? SETTLE : DWELL;
`else
          state_d = DWELL;
`endif
        end else begin
          ptr_d = ptr_inc;
          wrap  = (ptr == 2'd2);
        end
      end
`ifdef XY_SCAN_BLANK_EN
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = DWELL;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      DWELL: begin
        if (cnt == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = ARB;
          ptr_d   = ptr_inc;
          wrap    = (ptr == 2'd2);
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      ptr        <= 2'd0;
      cnt        <= '0;
      dac_x      <= 8'd0;
      dac_y      <= 8'd0;
      dac_z      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      cnt        <= cnt_d;
      dac_x      <= x_d;
      dac_y      <= y_d;
      dac_z      <= (state_d == DWELL);
      frame_done <= wrap;
    end
  end

endmodule

// File: doc/xy_scan_out.md
# xy_scan_out

Consumer end of the coordinate streams produced by the object view blocks (plates, ball). Arbitrates round-robin among three point sources, holds each accepted point on the 8-bit X/Y DAC outputs for a fixed dwell time, and inserts a blanked settle interval when the beam must jump a large distance. Sits between the view blocks and the DAC pins and produces one frame marker per arbitration pass.

## Interface
- DWELL_CYCLES, 4, cycles the beam is lit on each accepted point (≥1)
- SETTLE_CYCLES, 8, blanked cycles inserted before dwell on a large jump (≥1)
- JUMP_THRESH, 16, max per-axis distance (LSBs) drawn without settle
- clk  in  1  system clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- src0_x, src1_x, src2_x  in  8 each  point X from source 0/1/2
- src0_y, src1_y, src2_y  in  8 each  point Y from source 0/1/2
- src0_valid, src1_valid, src2_valid  in  1 each  source has a point presented
- src0_ready, src1_ready, src2_ready  out  1 each  scanner accepts point this cycle
- dac_x  out  8  registered X DAC code
- dac_y  out  8  registered Y DAC code
- dac_z  out  1  registered beam enable (1 = lit)
- frame_done  out  1  one-cycle pulse at end of each arbitration pass

## Operation
- Reset: state ARB, ptr=0, counter=0, dac_x=0, dac_y=0, dac_z=0, frame_done=0; all srcN_ready=0 while rst_n=0.
- Handshake: transfer when srcN_valid & srcN_ready on a rising edge. srcN_ready = (state==ARB) & (ptr==N) & srcN_valid, combinational. Source holds x/y stable while valid and not accepted.
- ARB: dac_z=0. If source[ptr] valid: latch x/y into dac_x/dac_y, compute dx=|x−dac_x|, dy=|y−dac_y| (9-bit unsigned subtract, magnitude), go SETTLE if dx>JUMP_THRESH or dy>JUMP_THRESH, else DWELL. If not valid: ptr advances by one, stay ARB.
- SETTLE: dac_z=0, coordinates held, SETTLE_CYCLES cycles, then DWELL.
- DWELL: dac_z=1, DWELL_CYCLES cycles, then ARB with ptr advanced by one.
- Pointer advance is 0→1→2→0; every 2→0 advance (skip or serviced) makes frame_done=1 for the next single cycle.
- Exactly one point per source per visit; a source streaming continuously is visited every third arbitration.
- Distance equal to JUMP_THRESH draws without settle. First point after reset is compared against (0,0).
- Reset mid-dwell/settle: immediate return to reset values; pending point is not re-presented by the scanner (source must keep valid).

## Timing
- Accepted point appears on dac_x/dac_y the cycle after transfer.
- Per point, no jump: 1 ARB cycle + DWELL_CYCLES lit cycles (5 at defaults).
- Per point, jump: 1 + SETTLE_CYCLES blanked + DWELL_CYCLES lit (13 at defaults).
- Skipped (invalid) source costs 1 ARB cycle; all idle → frame_done every 3 cycles, dac_z=0.
- dac_z rises exactly on the first DWELL cycle and falls on the first cycle after it.

## Configuration
- XY_SCAN_BLANK_EN defined: jump detection and SETTLE state present as above.
- Not defined: no SETTLE state, no distance compare; every accepted point goes straight to DWELL; dac_z still 0 in ARB, 1 in DWELL.

## Test plan
- Reset with all valids high: all ready=0 during reset; after release src0 accepted first, dac_x/dac_y follow src0, dac_z=0 then 1 for 4 cycles.
- Only src1 valid at (10,10) after reset: 1 skip cycle, accept, dx=10≤16 → no settle, dac_z high 4 cycles, next src1 accept 3 ARB cycles later with frame_done pulse between.
- Point (0,0)→(200,5): SETTLE 8 cycles with dac_z=0 and dac_x=200, then 4 lit cycles; same with XY_SCAN_BLANK_EN undefined → lit immediately.
- Boundary jump: dac at (100,100), next point (116,84) → no settle; (117,100) → settle.
- All three valid continuously: accept order 0,1,2,0,…; each ready high exactly one cycle per 15 cycles at defaults; frame_done once per pass.
- rst_n low during DWELL: dac_z, dac_x, dac_y, frame_done go 0 asynchronously; after release arbitration restarts at src0.
